// File: rtl/freq_to_note.sv
`default_nettype none
// freq_to_note: maps a frequency in Hz to the nearest piano key (1..88) by a
// fixed-length binary search over an equal-temperament ROM, plus the residual.
module freq_to_note #(
  parameter int LATENCY = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [13:0]        hz_in,
  output logic               busy,
  output logic               done,
  output logic [7:0]         note,
  output logic signed [14:0] delta,
  output logic               range_err
);

  // Two cycles of the latency go to ROUND and DONE; the rest are search steps.
  localparam int SEARCH_CYCLES = LATENCY - 2;
  localparam logic [2:0] LAST_ITER = 3'(SEARCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [13:0]        hz_q;
  logic [6:0]         lo;
  logic [6:0]         hi;
  logic [2:0]         iter;
  logic [6:0]         mid;
  logic               mid_le;
  logic [13:0]        t_lo;
  logic [13:0]        t_hi;
  logic signed [14:0] diff_dn;
  logic signed [14:0] diff_up;
  logic [6:0]         pick;
  logic signed [14:0] round_delta;
  logic               out_of_range;

  function automatic logic [13:0] note_hz(input logic [6:0] idx);
    logic [13:0] f;
    f = 14'd0;
    case (idx)
      7'd1:  f = 14'd28;   7'd2:  f = 14'd29;   7'd3:  f = 14'd31;   7'd4:  f = 14'd33;
      7'd5:  f = 14'd35;   7'd6:  f = 14'd37;   7'd7:  f = 14'd39;   7'd8:  f = 14'd41;
      7'd9:  f = 14'd44;   7'd10: f = 14'd46;   7'd11: f = 14'd49;   7'd12: f = 14'd52;
      7'd13: f = 14'd55;   7'd14: f = 14'd58;   7'd15: f = 14'd62;   7'd16: f = 14'd65;
      7'd17: f = 14'd69;   7'd18: f = 14'd73;   7'd19: f = 14'd78;   7'd20: f = 14'd82;
      7'd21: f = 14'd87;   7'd22: f = 14'd92;   7'd23: f = 14'd98;   7'd24: f = 14'd104;
      7'd25: f = 14'd110;  7'd26: f = 14'd117;  7'd27: f = 14'd123;  7'd28: f = 14'd131;
      7'd29: f = 14'd139;  7'd30: f = 14'd147;  7'd31: f = 14'd156;  7'd32: f = 14'd165;
      7'd33: f = 14'd175;  7'd34: f = 14'd185;  7'd35: f = 14'd196;  7'd36: f = 14'd208;
      7'd37: f = 14'd220;  7'd38: f = 14'd233;  7'd39: f = 14'd247;  7'd40: f = 14'd262;
      7'd41: f = 14'd277;  7'd42: f = 14'd294;  7'd43: f = 14'd311;  7'd44: f = 14'd330;
      7'd45: f = 14'd349;  7'd46: f = 14'd370;  7'd47: f = 14'd392;  7'd48: f = 14'd415;
      7'd49: f = 14'd440;  7'd50: f = 14'd466;  7'd51: f = 14'd494;  7'd52: f = 14'd523;
      7'd53: f = 14'd554;  7'd54: f = 14'd587;  7'd55: f = 14'd622;  7'd56: f = 14'd659;
      7'd57: f = 14'd698;  7'd58: f = 14'd740;  7'd59: f = 14'd784;  7'd60: f = 14'd831;
      7'd61: f = 14'd880;  7'd62: f = 14'd932;  7'd63: f = 14'd988;  7'd64: f = 14'd1047;
      7'd65: f = 14'd1109; 7'd66: f = 14'd1175; 7'd67: f = 14'd1245; 7'd68: f = 14'd1319;
      7'd69: f = 14'd1397; 7'd70: f = 14'd1480; 7'd71: f = 14'd1568; 7'd72: f = 14'd1661;
      7'd73: f = 14'd1760; 7'd74: f = 14'd1865; 7'd75: f = 14'd1976; 7'd76: f = 14'd2093;
      7'd77: f = 14'd2217; 7'd78: f = 14'd2349; 7'd79: f = 14'd2489; 7'd80: f = 14'd2637;
      7'd81: f = 14'd2794; 7'd82: f = 14'd2960; 7'd83: f = 14'd3136; 7'd84: f = 14'd3322;
      7'd85: f = 14'd3520; 7'd86: f = 14'd3729; 7'd87: f = 14'd3951; 7'd88: f = 14'd4186;
      default: f = 14'd0;
    endcase
    return f;
  endfunction

  // Upper-middle probe keeps lo as the largest index known to satisfy table <= hz.
  assign mid    = 7'(({1'b0, lo} + {1'b0, hi} + 8'd1) >> 1);
  assign mid_le = (note_hz(mid) <= hz_q);

  assign t_lo    = note_hz(lo);
  assign t_hi    = note_hz(lo + 7'd1);
  assign diff_dn = $signed({1'b0, hz_q}) - $signed({1'b0, t_lo});
  assign diff_up = $signed({1'b0, t_hi}) - $signed({1'b0, hz_q});
  assign pick    = ((lo < 7'd88) && (diff_up < diff_dn)) ? lo + 7'd1 : lo;
  assign round_delta  = $signed({1'b0, hz_q}) - $signed({1'b0, note_hz(pick)});
  assign out_of_range = (hz_q != 14'd0) && ((hz_q < 14'd28) || (hz_q > 14'd4186));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SEARCH;
      end
      SEARCH: begin
        busy = 1'b1;
        if (iter == LAST_ITER) state_next = ROUND;
      end
      ROUND: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_q      <= 14'd0;
      lo        <= 7'd0;
      hi        <= 7'd0;
      iter      <= 3'd0;
      note      <= 8'd0;
      delta     <= 15'sd0;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hz_q <= hz_in;
            lo   <= 7'd1;
            hi   <= 7'd88;
            iter <= 3'd0;
          end
        end
        SEARCH: begin
          iter <= iter + 3'd1;
          if (lo < hi) begin
            if (mid_le) lo <= mid;
            else        hi <= mid - 7'd1;
          end
        end
        ROUND: begin
          range_err <= out_of_range;
          if (hz_q == 14'd0) begin
            note  <= 8'd0;
            delta <= 15'sd0;
          end else begin
            note  <= {1'b0, pick};
            delta <= round_delta;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_to_note.sv
`default_nettype none
// tb_freq_to_note: directed vectors with hand-computed notes/residuals, plus
// sequences for start-while-busy, back-to-back starts and mid-flight reset.
module tb_freq_to_note;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [13:0]        hz_in;
  logic               busy;
  logic               done;
  logic [7:0]         note;
  logic signed [14:0] delta;
  logic               range_err;

  int checks = 0;
  int errors = 0;

  freq_to_note #(.LATENCY(9)) dut (
    .clk(clk), .rst(rst), .start(start), .hz_in(hz_in),
    .busy(busy), .done(done), .note(note), .delta(delta), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hz;
    int note;
    int delta;
    int err;
  } vec_t;

  vec_t vecs[12];
  int   tbl[89];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle k is the k-th cycle after the start cycle; done is expected in cycle 9
  // and busy in cycles 1..9. hz_in is scrambled right after acceptance.
  task automatic convert(input int hz, input bit poke_busy,
                         output int done_cycle, output int done_count, output int busy_bad);
    done_cycle = -1;
    done_count = 0;
    busy_bad   = 0;
    @(negedge clk);
    hz_in = 14'(hz);
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        hz_in = ~hz_in;
      end
      if (poke_busy && k == 3) start = 1'b1;
      if (poke_busy && k == 4) start = 1'b0;
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (busy !== (k <= 9)) busy_bad++;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit poke_busy);
    int dc, dn, bb;
    convert(v.hz, poke_busy, dc, dn, bb);
    check($sformatf("done_cycle hz=%0d", v.hz), dc, 9);
    check($sformatf("done_count hz=%0d", v.hz), dn, 1);
    check($sformatf("busy_window hz=%0d", v.hz), bb, 0);
    check($sformatf("note hz=%0d", v.hz), int'(note), v.note);
    check($sformatf("delta hz=%0d", v.hz), int'(delta), v.delta);
    check($sformatf("range_err hz=%0d", v.hz), int'(range_err), v.err);
  endtask

  initial begin
    int dc, dn, bb;
    int done_at[$];
    int no_done;

    tbl = '{0,
            28, 29, 31, 33, 35, 37, 39, 41, 44, 46, 49, 52,
            55, 58, 62, 65, 69, 73, 78, 82, 87, 92, 98, 104,
            110, 117, 123, 131, 139, 147, 156, 165, 175, 185, 196, 208,
            220, 233, 247, 262, 277, 294, 311, 330, 349, 370, 392, 415,
            440, 466, 494, 523, 554, 587, 622, 659, 698, 740, 784, 831,
            880, 932, 988, 1047, 1109, 1175, 1245, 1319, 1397, 1480, 1568, 1661,
            1760, 1865, 1976, 2093, 2217, 2349, 2489, 2637, 2794, 2960, 3136, 3322,
            3520, 3729, 3951, 4186};

    vecs[0]  = '{440,   49,     0, 0};
    vecs[1]  = '{453,   49,    13, 0};
    vecs[2]  = '{454,   50,   -12, 0};
    vecs[3]  = '{0,      0,     0, 0};
    vecs[4]  = '{10,     1,   -18, 1};
    vecs[5]  = '{28,     1,     0, 0};
    vecs[6]  = '{4186,  88,     0, 0};
    vecs[7]  = '{5000,  88,   814, 1};
    vecs[8]  = '{27,     1,    -1, 1};
    vecs[9]  = '{4187,  88,     1, 1};
    vecs[10] = '{16383, 88, 12197, 1};
    vecs[11] = '{300,   42,     6, 0};

    rst   = 1'b1;
    start = 1'b0;
    hz_in = 14'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset note", int'(note), 0);
    check("reset delta", int'(delta), 0);
    check("reset range_err", int'(range_err), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // A start pulse mid-search must neither restart nor queue a conversion.
    run_vec('{880, 61, 0, 0}, 1'b1);

    for (int n = 1; n <= 88; n++) begin
      convert(tbl[n], 1'b0, dc, dn, bb);
      check($sformatf("sweep done n=%0d", n), dn, 1);
      check($sformatf("sweep note n=%0d", n), int'(note), n);
      check($sformatf("sweep delta n=%0d", n), int'(delta), 0);
    end

    // Start held through DONE into IDLE: only the IDLE sample is accepted.
    @(negedge clk);
    hz_in = 14'd440;
    start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 9) begin
        start = 1'b1;
        hz_in = 14'd454;
        check("b2b first note", int'(note), 49);
      end
      if (k == 11) start = 1'b0;
      if (done) done_at.push_back(k);
    end
    check("b2b done count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("b2b first done", done_at[0], 9);
      check("b2b second done", done_at[1], 19);
    end
    check("b2b second note", int'(note), 50);
    check("b2b second delta", int'(delta), -12);

    // Make outputs nonzero, then abort a conversion with reset.
    run_vec(vecs[7], 1'b0);
    @(negedge clk);
    hz_in   = 14'd440;
    start   = 1'b1;
    no_done = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort note", int'(note), 0);
        check("abort delta", int'(delta), 0);
        check("abort range_err", int'(range_err), 0);
      end
      if (done) no_done++;
    end
    check("abort no done", no_done, 0);
    run_vec('{262, 40, 0, 0}, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    hz_in = 14'd440;
    @(posedge clk); #1;
    check("rst priority busy", int'(busy), 0);
    @(negedge clk);
    rst     = 1'b0;
    start   = 1'b0;
    no_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) no_done++;
    end
    check("rst priority idle", no_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
